pipeline_flow_ctrl: RTL and testbench

//  Flow controller for one or more fixed-latency enable-gated delay pipelines that share a

---
 rtl/pipeline_flow_ctrl.sv | 107 ++++++++++
 tb/tb_pipeline_flow_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_flow_ctrl.sv
// Flow controller for enable-gated fixed-latency pipelines: shared enable, per-stage valid
// tracking, upstream valid/ready, downstream credit counting and a stop/drain/restart FSM.
module pipeline_flow_ctrl #(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 8,
    localparam int CWIDTH = $clog2(CREDITS + 1),
    localparam int IWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_en,
    output logic              o_out_valid,
    input  logic              i_credit_ret,
    input  logic              i_stop,
    input  logic              i_start,
    output logic              o_stopped,
    output logic [CWIDTH-1:0] o_credits,
    output logic [IWIDTH-1:0] o_inflight,
    output logic              o_credit_err
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_STOPPED} state_t;

    localparam logic [CWIDTH-1:0] CRED_MAX = CWIDTH'(CREDITS);

    state_t            state_q;
    logic [DEPTH-1:0]  v_q, v_d;
    logic [CWIDTH-1:0] credits_q, credits_d;
    logic              err_q, err_d;
    logic              can_adv, en, accept, out_valid;
    logic [IWIDTH-1:0] inflight;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight = inflight + IWIDTH'(v_q[k]);
        end
    end

    // Only a valid tail item with no buffer slot stalls the pipeline.
    assign can_adv   = !v_q[DEPTH-1] || (credits_q != '0);
    assign en        = !rst && can_adv && (state_q != S_STOPPED);
    assign accept    = i_valid && en && (state_q == S_RUN);
    assign out_valid = v_q[DEPTH-1] && en;

    assign v_d[0] = en ? accept : v_q[0];
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_valid_shift
            assign v_d[gi] = en ? v_q[gi-1] : v_q[gi];
        end
    endgenerate

    // A write and a return in the same cycle cancel, so overflow only arises without a write.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({i_credit_ret, out_valid})
            2'b10: begin
                if (credits_q == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CWIDTH'(1);
                end
            end
            2'b01:   credits_d = credits_q - CWIDTH'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            v_q       <= '0;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
        end else begin
            v_q       <= v_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            case (state_q)
                S_RUN: begin
                    if (i_stop) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((inflight == '0) || ((inflight == IWIDTH'(1)) && out_valid)) begin
                        state_q <= S_STOPPED;
                    end
                end
                S_STOPPED: begin
                    if (i_start && !i_stop) state_q <= S_RUN;
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign o_en         = en;
    assign o_ready      = en && (state_q == S_RUN);
    assign o_out_valid  = out_valid;
    assign o_stopped    = !rst && (state_q == S_STOPPED);
    assign o_credits    = credits_q;
    assign o_inflight   = rst ? '0 : inflight;
    assign o_credit_err = err_q;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Bench for pipeline_flow_ctrl: a 2-credit and an 8-credit instance share stimulus; a tagged
// shadow pipeline on the 8-credit instance scoreboards every item leaving the tail.
module tb_pipeline_flow_ctrl;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst, i_valid, i_credit_ret, i_stop, i_start;
    logic ready_a, en_a, ov_a, stopped_a, err_a;
    logic [1:0] cred_a;
    logic [2:0] infl_a;
    logic ready_b, en_b, ov_b, stopped_b, err_b;
    logic [3:0] cred_b;
    logic [2:0] infl_b;

    int tests_run = 0;
    int tests_failed = 0;
    int sb_q[$];
    int pipe_tag[DEPTH];
    int next_tag = 0;

    always #5 clk = ~clk;

    pipeline_flow_ctrl #(.DEPTH(DEPTH), .CREDITS(2)) dut_a (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(ready_a), .o_en(en_a),
        .o_out_valid(ov_a), .i_credit_ret(i_credit_ret), .i_stop(i_stop), .i_start(i_start),
        .o_stopped(stopped_a), .o_credits(cred_a), .o_inflight(infl_a), .o_credit_err(err_a));

    pipeline_flow_ctrl #(.DEPTH(DEPTH), .CREDITS(8)) dut_b (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(ready_b), .o_en(en_b),
        .o_out_valid(ov_b), .i_credit_ret(i_credit_ret), .i_stop(i_stop), .i_start(i_start),
        .o_stopped(stopped_b), .o_credits(cred_b), .o_inflight(infl_b), .o_credit_err(err_b));

    // Shadow data pipeline advanced by o_en; each tail strobe must deliver the oldest tag.
    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
            for (int k = 0; k < DEPTH; k++) pipe_tag[k] <= -1;
        end else begin
            if (ov_b) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_tail: got tag %0d, required no output (queue empty)", pipe_tag[DEPTH-1]);
                end else begin
                    int exp_tag;
                    exp_tag = sb_q.pop_front();
                    if (pipe_tag[DEPTH-1] !== exp_tag) begin
                        tests_failed++;
                        $display("FAIL sb_tail: got tag %0d, required %0d", pipe_tag[DEPTH-1], exp_tag);
                    end else begin
                        $display("[TB] out tag %0d", exp_tag);
                    end
                end
            end
            if (en_b) begin
                for (int k = DEPTH - 1; k > 0; k--) pipe_tag[k] <= pipe_tag[k-1];
                if (i_valid && ready_b) begin
                    pipe_tag[0] <= next_tag;
                    sb_q.push_back(next_tag);
                    next_tag <= next_tag + 1;
                end else begin
                    pipe_tag[0] <= -1;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; i_credit_ret = 1'b0; i_stop = 1'b0; i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; i_credit_ret = 1'b0; i_stop = 1'b0; i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if ({en_a, ready_a, ov_a, stopped_a, en_b, ready_b, ov_b, stopped_b} !== 8'h00 ||
            infl_a !== 3'd0 || infl_b !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_gated: en/ready/ov/stopped a,b = %b%b%b%b %b%b%b%b infl %0d %0d, required all 0",
                     en_a, ready_a, ov_a, stopped_a, en_b, ready_b, ov_b, stopped_b, infl_a, infl_b);
        end
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0;
        #1;
        tests_run++;
        if (cred_a !== 2'd2 || cred_b !== 4'd8 || err_a !== 1'b0 || err_b !== 1'b0 ||
            ready_b !== 1'b1 || stopped_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: cred %0d/%0d err %b/%b ready %b stopped %b, required 2/8 0/0 1 0",
                     cred_a, cred_b, err_a, err_b, ready_b, stopped_b);
        end
        $display("[TB] reset state checked");
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            logic exp_ov, exp_en;
            int exp_cr;
            i_valid = 1'b1;
            i_credit_ret = (c == 10) || (c >= 12);
            #1;
            exp_ov = (c == 4) || (c == 5) || (c == 11) || (c >= 13);
            exp_en = !((c >= 6 && c <= 10) || c == 12);
            exp_cr = (c <= 4) ? 2 : (c == 5) ? 1 : (c <= 10) ? 0 : (c == 11) ? 1 : (c == 12) ? 0 : 1;
            tests_run++;
            if (ov_a !== exp_ov || en_a !== exp_en || ready_a !== exp_en || int'(cred_a) != exp_cr) begin
                tests_failed++;
                $display("FAIL backpressure c%0d: ov %b en %b ready %b cred %0d, required %b %b %b %0d",
                         c, ov_a, en_a, ready_a, cred_a, exp_ov, exp_en, exp_en, exp_cr);
            end
            if (c >= 6 && c <= 10) begin
                tests_run++;
                if (infl_a !== 3'd4) begin
                    tests_failed++;
                    $display("FAIL stall_inflight c%0d: got %0d, required 4", c, infl_a);
                end
            end
            $display("[TB] bp c%0d en=%b ov=%b cred=%0d", c, en_a, ov_a, cred_a);
            @(negedge clk);
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            i_valid = (c < 3) || (c >= 4);
            i_stop = (c == 3) || (c == 8) || (c == 11);
            i_start = (c == 9) || (c == 11);
            #1;
            if (c == 3) begin
                tests_run++;
                if (infl_b !== 3'd3 || ready_b !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL drain_pre: inflight %0d ready %b, required 3 1", infl_b, ready_b);
                end
            end
            if (c >= 4 && c <= 6) begin
                tests_run++;
                if (ready_b !== 1'b0 || ov_b !== 1'b1 || stopped_b !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL draining c%0d: ready %b ov %b stopped %b, required 0 1 0", c, ready_b, ov_b, stopped_b);
                end
            end
            if (c >= 7 && c <= 9) begin
                tests_run++;
                if (stopped_b !== 1'b1 || en_b !== 1'b0 || ready_b !== 1'b0 || ov_b !== 1'b0 || infl_b !== 3'd0) begin
                    tests_failed++;
                    $display("FAIL stopped c%0d: stopped %b en %b ready %b ov %b infl %0d, required 1 0 0 0 0",
                             c, stopped_b, en_b, ready_b, ov_b, infl_b);
                end
            end
            if (c == 10) begin
                tests_run++;
                if (ready_b !== 1'b1 || stopped_b !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL restart: ready %b stopped %b, required 1 0", ready_b, stopped_b);
                end
            end
            if (c == 12) begin
                tests_run++;
                if (ready_b !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stop_wins: ready %b, required 0", ready_b);
                end
            end
            $display("[TB] drain c%0d ready=%b ov=%b stopped=%b", c, ready_b, ov_b, stopped_b);
            @(negedge clk);
        end
        i_stop = 1'b0; i_start = 1'b0;
    endtask

    task automatic test_credit_overflow();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            i_credit_ret = (c == 0);
            i_valid = (c >= 2);
            #1;
            tests_run++;
            if (c == 0) begin
                if (err_b !== 1'b0 || cred_b !== 4'd8) begin
                    tests_failed++;
                    $display("FAIL overflow_pre: err %b cred %0d, required 0 8", err_b, cred_b);
                end
            end else if (err_b !== 1'b1) begin
                tests_failed++;
                $display("FAIL overflow_sticky c%0d: err %b, required 1", c, err_b);
            end
            if (c == 1 || c == 8) begin
                tests_run++;
                if (int'(cred_b) != ((c == 1) ? 8 : 6)) begin
                    tests_failed++;
                    $display("FAIL overflow_cred c%0d: got %0d, required %0d", c, cred_b, (c == 1) ? 8 : 6);
                end
            end
            $display("[TB] ovf c%0d err=%b cred=%0d", c, err_b, cred_b);
            @(negedge clk);
        end
        do_reset();
        #1;
        tests_run++;
        if (err_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear: err %b, required 0", err_b);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            i_valid = (c < 6);
            @(negedge clk);
        end
        i_valid = 1'b0;
        #1;
        tests_run++;
        if (infl_b !== 3'd3 || cred_b !== 4'd5) begin
            tests_failed++;
            $display("FAIL midflight_pre: inflight %0d cred %0d, required 3 5", infl_b, cred_b);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (en_b !== 1'b0 || ov_b !== 1'b0 || ready_b !== 1'b0 || infl_b !== 3'd0) begin
            tests_failed++;
            $display("FAIL midflight_gate: en %b ov %b ready %b infl %0d, required 0 0 0 0", en_b, ov_b, ready_b, infl_b);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (infl_b !== 3'd0 || cred_b !== 4'd8 || stopped_b !== 1'b0 || ready_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL midflight_post: infl %0d cred %0d stopped %b ready %b, required 0 8 0 1",
                     infl_b, cred_b, stopped_b, ready_b);
        end
        for (int c = 0; c < DEPTH + 2; c++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (ov_b !== 1'b0) begin
                tests_failed++;
                $display("FAIL midflight_dropped c%0d: ov %b, required 0", c, ov_b);
            end
        end
        $display("[TB] reset mid-flight checked");
    endtask

    task automatic test_back_to_back();
        int occ;
        occ = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic ret;
            i_valid = ($urandom_range(0, 3) != 0);
            ret = (occ > 0) && ($urandom_range(0, 2) == 0);
            i_credit_ret = ret;
            #1;
            tests_run++;
            if (int'(cred_b) != 8 - occ || err_b !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_credits c%0d: cred %0d err %b, required %0d 0", c, cred_b, err_b, 8 - occ);
            end
            occ = occ + (ov_b ? 1 : 0) - (ret ? 1 : 0);
            @(negedge clk);
        end
        i_valid = 1'b0;
        for (int c = 0; c < 200 && !(infl_b == 3'd0 && occ == 0); c++) begin
            logic ret;
            ret = (occ > 0);
            i_credit_ret = ret;
            #1;
            occ = occ + (ov_b ? 1 : 0) - (ret ? 1 : 0);
            @(negedge clk);
        end
        i_credit_ret = 1'b0;
        #1;
        tests_run++;
        if (infl_b !== 3'd0 || sb_q.size() != 0 || cred_b !== 4'd8) begin
            tests_failed++;
            $display("FAIL b2b_drain: infl %0d pending %0d cred %0d, required 0 0 8", infl_b, sb_q.size(), cred_b);
        end
        $display("[TB] back-to-back traffic done");
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_credit_ret = 1'b0; i_stop = 1'b0; i_start = 1'b0;
        test_reset();
        test_backpressure();
        test_drain();
        test_credit_overflow();
        test_reset_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
